// File: rtl/bus_initiator.sv
// bus_initiator: single-beat initiator for the shared multiplexed address/data bus.
// Takes one client request at a time, arbitrates for the bus, runs the
// begin/data/end phases, and reports completion with a one-cycle done pulse.
module bus_initiator #(
    parameter logic [15:0] timeoutCycles = 16'd1023
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        requestStart,
    input  logic        requestReadNWrite,
    input  logic [31:0] requestAddress,
    input  logic [31:0] requestWriteData,
    input  logic [3:0]  requestByteEnables,
    output logic        requestBusy,
    output logic        requestDone,
    output logic        requestError,
    output logic [31:0] requestReadData,
    output logic        requestTransaction,
    input  logic        transactionGranted,
    output logic        beginTransactionOut,
    output logic        endTransactionOut,
    output logic        readNWriteOut,
    output logic        dataValidOut,
    output logic        busyOut,
    output logic [31:0] addressDataOut,
    output logic [3:0]  byteEnablesOut,
    output logic [7:0]  burstSizeOut,
    input  logic [31:0] addressDataIn,
    input  logic        dataValidIn,
    input  logic        endTransactionIn,
    input  logic        busErrorIn
);

    typedef enum logic [2:0] {
        stateIdle,
        stateArb,
        stateBegin,
        stateWriteData,
        stateWriteEnd,
        stateReadWait,
        stateAbort,
        stateDone
    } stateType;

    stateType    state;
    stateType    nextState;

    logic        latchedReadNWrite;
    logic [31:0] latchedAddress;
    logic [31:0] latchedWriteData;
    logic [3:0]  latchedByteEnables;
    logic [15:0] timeoutCount;
    logic        dataCaptured;
    logic        errorFlag;
    logic [31:0] readData;
    logic        timeoutHit;

    // The counter holds timeoutCycles in the first wait cycle, so the last
    // permitted wait cycle sees 1; abort is then taken on that cycle's edge.
    always_comb begin
        timeoutHit = (timeoutCount <= 16'd1);
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= stateIdle;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode; bus error beats end-of-transaction beats timeout
    always_comb begin
        nextState = state;
        case (state)
            stateIdle:      if (requestStart) nextState = stateArb;
            stateArb:       if (transactionGranted) nextState = stateBegin;
            stateBegin:     nextState = latchedReadNWrite ? stateReadWait : stateWriteData;
            stateWriteData: nextState = stateWriteEnd;
            stateWriteEnd:  nextState = stateDone;
            stateReadWait: begin
                if (busErrorIn) begin
                    nextState = stateAbort;
                end else if (endTransactionIn) begin
                    nextState = stateDone;
                end else if (timeoutHit) begin
                    nextState = stateAbort;
                end
            end
            stateAbort:     nextState = stateDone;
            stateDone:      nextState = stateIdle;
            default:        nextState = stateIdle;
        endcase
    end

    // Request latch, timeout counter, read-data capture and sticky error flag
    always_ff @(posedge clock) begin
        if (reset) begin
            latchedReadNWrite  <= 1'b0;
            latchedAddress     <= '0;
            latchedWriteData   <= '0;
            latchedByteEnables <= '0;
            timeoutCount       <= '0;
            dataCaptured       <= 1'b0;
            errorFlag          <= 1'b0;
            readData           <= '0;
        end else begin
            case (state)
                stateIdle: begin
                    if (requestStart) begin
                        latchedReadNWrite  <= requestReadNWrite;
                        latchedAddress     <= requestAddress;
                        latchedWriteData   <= requestWriteData;
                        latchedByteEnables <= requestByteEnables;
                    end
                end
                stateBegin: begin
                    dataCaptured <= 1'b0;
                    if (latchedReadNWrite) begin
                        timeoutCount <= timeoutCycles;
                    end
                end
                stateWriteData, stateWriteEnd: begin
                    if (busErrorIn) begin
                        errorFlag <= 1'b1;
                    end
                end
                stateReadWait: begin
                    if (timeoutCount != '0) begin
                        timeoutCount <= timeoutCount - 16'd1;
                    end
                    if (dataValidIn && !dataCaptured) begin
                        readData     <= addressDataIn;
                        dataCaptured <= 1'b1;
                    end
                    if (busErrorIn) begin
                        errorFlag <= 1'b1;
                    end else if (endTransactionIn) begin
                        if (!dataCaptured && !dataValidIn) begin
                            errorFlag <= 1'b1;
                        end
                    end else if (timeoutHit) begin
                        errorFlag <= 1'b1;
                    end
                end
                stateDone: begin
                    errorFlag <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from state and registered request fields only
    always_comb begin
        requestBusy         = (state != stateIdle);
        requestDone         = (state == stateDone);
        requestError        = (state == stateDone) && errorFlag;
        requestReadData     = readData;
        requestTransaction  = (state != stateIdle) && (state != stateDone);
        beginTransactionOut = (state == stateBegin);
        endTransactionOut   = (state == stateWriteEnd) || (state == stateAbort);
        readNWriteOut       = (state == stateBegin) && latchedReadNWrite;
        dataValidOut        = (state == stateWriteData);
        busyOut             = 1'b0;
        burstSizeOut        = '0;
        addressDataOut      = '0;
        byteEnablesOut      = '0;
        if (state == stateBegin) begin
            addressDataOut = latchedAddress;
            byteEnablesOut = latchedByteEnables;
        end else if (state == stateWriteData) begin
            addressDataOut = latchedWriteData;
        end
    end

endmodule

// File: tb/tb_bus_initiator.sv
// tb_bus_initiator: table-driven bench with a done-pulse scoreboard for bus_initiator.
module tb_bus_initiator;

    localparam int unsigned LongTimeout = 1023;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        requestStart = 1'b0;
    logic        requestReadNWrite = 1'b0;
    logic [31:0] requestAddress = '0;
    logic [31:0] requestWriteData = '0;
    logic [3:0]  requestByteEnables = '0;
    logic        requestBusy, requestDone, requestError, requestTransaction;
    logic [31:0] requestReadData;
    logic        transactionGranted = 1'b0;
    logic        beginTransactionOut, endTransactionOut, readNWriteOut, dataValidOut, busyOut;
    logic [31:0] addressDataOut;
    logic [3:0]  byteEnablesOut;
    logic [7:0]  burstSizeOut;
    logic [31:0] addressDataIn = '0;
    logic        dataValidIn = 1'b0;
    logic        endTransactionIn = 1'b0;
    logic        busErrorIn = 1'b0;

    // Second instance with a short timeout; no responder attached
    logic        sStart = 1'b0;
    logic        sGrant = 1'b0;
    logic        sZero = 1'b0;
    logic [31:0] sZeroWord = '0;
    logic        sBusy, sDone, sError, sTransaction, sBegin, sEnd, sReadNWrite, sDataValid, sBusyOut;
    logic [31:0] sReadData, sAddressData;
    logic [3:0]  sByteEnables;
    logic [7:0]  sBurst;

    bus_initiator #(.timeoutCycles(16'd1023)) dut (
        .clock(clock), .reset(reset),
        .requestStart(requestStart), .requestReadNWrite(requestReadNWrite),
        .requestAddress(requestAddress), .requestWriteData(requestWriteData),
        .requestByteEnables(requestByteEnables),
        .requestBusy(requestBusy), .requestDone(requestDone), .requestError(requestError),
        .requestReadData(requestReadData), .requestTransaction(requestTransaction),
        .transactionGranted(transactionGranted),
        .beginTransactionOut(beginTransactionOut), .endTransactionOut(endTransactionOut),
        .readNWriteOut(readNWriteOut), .dataValidOut(dataValidOut), .busyOut(busyOut),
        .addressDataOut(addressDataOut), .byteEnablesOut(byteEnablesOut),
        .burstSizeOut(burstSizeOut),
        .addressDataIn(addressDataIn), .dataValidIn(dataValidIn),
        .endTransactionIn(endTransactionIn), .busErrorIn(busErrorIn)
    );

    bus_initiator #(.timeoutCycles(16'd4)) shortDut (
        .clock(clock), .reset(reset),
        .requestStart(sStart), .requestReadNWrite(1'b1),
        .requestAddress(32'h0000_0040), .requestWriteData(sZeroWord),
        .requestByteEnables(4'hF),
        .requestBusy(sBusy), .requestDone(sDone), .requestError(sError),
        .requestReadData(sReadData), .requestTransaction(sTransaction),
        .transactionGranted(sGrant),
        .beginTransactionOut(sBegin), .endTransactionOut(sEnd),
        .readNWriteOut(sReadNWrite), .dataValidOut(sDataValid), .busyOut(sBusyOut),
        .addressDataOut(sAddressData), .byteEnablesOut(sByteEnables),
        .burstSizeOut(sBurst),
        .addressDataIn(sZeroWord), .dataValidIn(sZero),
        .endTransactionIn(sZero), .busErrorIn(sZero)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rnw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          grantDelay;  // ARB cycles before grant
        int          errCycle;    // write: 1=WDATA 2=WEND; read: wait cycle index; 0=none
        int          dataDelay;   // read: wait cycle index of first dataValidIn; 0=none
        logic [31:0] rdata;
        logic        dupData;     // second dataValidIn the following cycle
        int          endDelay;    // read: wait cycle index of endTransactionIn; 0=none
        logic        expErr;
        logic        checkData;
        logic [31:0] expData;
    } vecType;

    typedef struct {
        logic        err;
        logic        checkData;
        logic [31:0] data;
    } expType;

    vecType vecs[11];
    expType sb[$];
    int     vectorCount = 0;
    int     missCount = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance one cycle and sample just after the edge; every done pulse is scored here
    task automatic tick();
        expType e;
        @(posedge clock);
        #1;
        if (requestDone === 1'b1) begin
            if (sb.size() == 0) begin
                vectorCount++;
                missCount++;
                $display("FAIL unexpectedDone actual=1 required=0 at %0t", $time);
            end else begin
                e = sb.pop_front();
                check("doneError", {31'b0, requestError}, {31'b0, e.err});
                if (e.checkData) check("doneReadData", requestReadData, e.data);
            end
        end
    endtask

    task automatic runVector(input vecType v, input int idx);
        int term, abortCycle, doneCycle;
        expType e;
        // Called in an IDLE cycle
        requestReadNWrite  = v.rnw;
        requestAddress     = v.addr;
        requestWriteData   = v.wdata;
        requestByteEnables = v.be;
        requestStart       = 1'b1;
        e.err = v.expErr; e.checkData = v.checkData; e.data = v.expData;
        sb.push_back(e);
        tick();
        requestStart = 1'b0;
        check($sformatf("v%0d arbReq", idx), {31'b0, requestTransaction}, 32'd1);
        check($sformatf("v%0d arbBusy", idx), {31'b0, requestBusy}, 32'd1);
        for (int i = 0; i < v.grantDelay; i++) begin
            requestStart      = 1'b1;
            requestAddress    = 32'hBAD0_0000 | i;
            requestReadNWrite = ~v.rnw;
            tick();
            check($sformatf("v%0d waitBegin", idx), {31'b0, beginTransactionOut}, 32'd0);
            check($sformatf("v%0d waitBus", idx), addressDataOut, 32'd0);
            check($sformatf("v%0d waitReq", idx), {31'b0, requestTransaction}, 32'd1);
        end
        requestStart = 1'b0;
        transactionGranted = 1'b1;
        tick();
        transactionGranted = 1'b0;
        check($sformatf("v%0d begin", idx), {31'b0, beginTransactionOut}, 32'd1);
        check($sformatf("v%0d beginAddr", idx), addressDataOut, v.addr);
        check($sformatf("v%0d beginRnw", idx), {31'b0, readNWriteOut}, {31'b0, v.rnw});
        check($sformatf("v%0d beginBe", idx), {28'b0, byteEnablesOut}, {28'b0, v.be});
        if (!v.rnw) begin
            tick();
            busErrorIn = (v.errCycle == 1);
            endTransactionIn = 1'b1;
            dataValidIn = 1'b1;
            check($sformatf("v%0d wdataValid", idx), {31'b0, dataValidOut}, 32'd1);
            check($sformatf("v%0d wdataBus", idx), addressDataOut, v.wdata);
            check($sformatf("v%0d wdataBe", idx), {28'b0, byteEnablesOut}, 32'd0);
            tick();
            busErrorIn = (v.errCycle == 2);
            endTransactionIn = 1'b0;
            dataValidIn = 1'b0;
            check($sformatf("v%0d wendEnd", idx), {31'b0, endTransactionOut}, 32'd1);
            check($sformatf("v%0d wendBus", idx), addressDataOut, 32'd0);
            tick();
            busErrorIn = 1'b0;
            check($sformatf("v%0d done", idx), {31'b0, requestDone}, 32'd1);
            check($sformatf("v%0d doneReq", idx), {31'b0, requestTransaction}, 32'd0);
            check($sformatf("v%0d doneBusy", idx), {31'b0, requestBusy}, 32'd1);
        end else begin
            if (v.errCycle != 0) begin
                term = v.errCycle; abortCycle = term + 1; doneCycle = term + 2;
            end else if (v.endDelay != 0) begin
                term = v.endDelay; abortCycle = 0; doneCycle = term + 1;
            end else begin
                term = LongTimeout; abortCycle = term + 1; doneCycle = term + 2;
            end
            for (int k = 1; k <= doneCycle; k++) begin
                tick();
                if (k <= term) begin
                    dataValidIn = (k == v.dataDelay) || (v.dupData && k == v.dataDelay + 1);
                    addressDataIn = (k == v.dataDelay) ? v.rdata :
                                    (dataValidIn ? ~v.rdata : (32'hDEAD_0000 | k));
                    busErrorIn = (k == v.errCycle);
                    endTransactionIn = (k == v.endDelay);
                end else begin
                    dataValidIn = 1'b0; busErrorIn = 1'b0; endTransactionIn = 1'b0;
                    addressDataIn = '0;
                end
                check($sformatf("v%0d rEnd k%0d", idx, k), {31'b0, endTransactionOut},
                      {31'b0, (k == abortCycle)});
                check($sformatf("v%0d rDone k%0d", idx, k), {31'b0, requestDone},
                      {31'b0, (k == doneCycle)});
                if (v.dataDelay != 0 && k == v.dataDelay + 1)
                    check($sformatf("v%0d rDataEarly", idx), requestReadData, v.rdata);
            end
        end
        tick();
        check($sformatf("v%0d idleBusy", idx), {31'b0, requestBusy}, 32'd0);
        check($sformatf("v%0d idleDone", idx), {31'b0, requestDone}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          rnw   addr          wdata         be       gd err dd rdata         dup  end  err  chk  expData
        vecs[0]  = '{1'b0, 32'h5000_0003, 32'hA500_0000, 4'b1000, 0, 0, 0, 32'h0,         1'b0, 0,    1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'h4000_0010, 32'h0,         4'b1111, 2, 0, 3, 32'h1234_5678, 1'b1, 5,    1'b0, 1'b1, 32'h1234_5678};
        vecs[2]  = '{1'b0, 32'h5000_0008, 32'h0000_0077, 4'b0001, 0, 1, 0, 32'h0,         1'b0, 0,    1'b1, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 32'h5000_0000, 32'h0,         4'b1111, 1, 2, 0, 32'h0,         1'b0, 0,    1'b1, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 32'h5000_0004, 32'h0,         4'b0011, 0, 0, 0, 32'h0,         1'b0, 2,    1'b1, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 32'h0000_0010, 32'h1234_0000, 4'b1100, 3, 2, 0, 32'h0,         1'b0, 0,    1'b1, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 32'h0000_0020, 32'h0,         4'b1111, 0, 0, 1, 32'hCAFE_F00D, 1'b0, 1,    1'b0, 1'b1, 32'hCAFE_F00D};
        vecs[7]  = '{1'b0, 32'h0000_0004, 32'hFFFF_FFFF, 4'b0101, 10, 0, 0, 32'h0,        1'b0, 0,    1'b0, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 32'h0000_0030, 32'h0,         4'b1111, 0, 0, 0, 32'h0,         1'b0, 0,    1'b1, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 32'h0000_0034, 32'h0,         4'b1111, 0, 0, 1, 32'h0BAD_BEEF, 1'b1, 1023, 1'b0, 1'b1, 32'h0BAD_BEEF};
        vecs[10] = '{1'b1, 32'h0000_0038, 32'h0,         4'b1111, 0, 3, 1, 32'h1111_2222, 1'b0, 3,    1'b1, 1'b1, 32'h1111_2222};

        reset = 1'b1;
        tick(); tick(); tick();
        reset = 1'b0;
        check("rstBusy", {31'b0, requestBusy}, 32'd0);
        check("rstDone", {31'b0, requestDone}, 32'd0);
        check("rstReq", {31'b0, requestTransaction}, 32'd0);
        check("rstBegin", {31'b0, beginTransactionOut}, 32'd0);
        check("rstEnd", {31'b0, endTransactionOut}, 32'd0);
        check("rstBus", addressDataOut, 32'd0);
        check("rstReadData", requestReadData, 32'd0);
        check("rstBusyOut", {31'b0, busyOut}, 32'd0);
        check("rstBurst", {24'b0, burstSizeOut}, 32'd0);

        // Back-to-back: each vector starts in the IDLE cycle right after the previous DONE
        for (int i = 0; i < 11; i++) begin
            runVector(vecs[i], i);
            if (i == 2) check("readDataHeldOverWrite", requestReadData, 32'h1234_5678);
        end

        // Short-timeout instance: no responder, abort five cycles after begin
        sStart = 1'b1;
        tick();
        sStart = 1'b0;
        sGrant = 1'b1;
        tick();
        sGrant = 1'b0;
        check("shortBegin", {31'b0, sBegin}, 32'd1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("shortEnd k%0d", k), {31'b0, sEnd}, {31'b0, (k == 5)});
            check($sformatf("shortDone k%0d", k), {31'b0, sDone}, {31'b0, (k == 6)});
            if (k == 6) check("shortError", {31'b0, sError}, 32'd1);
        end
        tick();
        check("shortIdle", {31'b0, sBusy}, 32'd0);

        // Reset in the middle of a read wait
        requestReadNWrite = 1'b1;
        requestAddress = 32'h0000_0044;
        requestStart = 1'b1;
        tick();
        requestStart = 1'b0;
        transactionGranted = 1'b1;
        tick();
        transactionGranted = 1'b0;
        tick(); tick(); tick();
        check("preRstBusy", {31'b0, requestBusy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midRstBusy", {31'b0, requestBusy}, 32'd0);
        check("midRstReq", {31'b0, requestTransaction}, 32'd0);
        check("midRstDone", {31'b0, requestDone}, 32'd0);
        check("midRstEnd", {31'b0, endTransactionOut}, 32'd0);
        check("midRstBus", addressDataOut, 32'd0);
        check("midRstReadData", requestReadData, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("postRstDone", {31'b0, requestDone}, 32'd0);
            check("postRstEnd", {31'b0, endTransactionOut}, 32'd0);
        end
        runVector(vecs[0], 11);

        check("scoreboardEmpty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
